adder_cache_scheduler: RTL and testbench
========================================

# adder_cache_scheduler

Round-robin scheduler that shares the pipelined 8-bit adder cache (two-stage add pipeline feeding a 64×8 RAM with a registered read port) among NREQ requesters. It accepts one write (compute a+b, store at address) or read (fetch cached sum) per cycle and drives the adder's ren/wen/address/operand inputs from registers. It blocks reads that would hit a write still inside the adder pipeline, and returns read data tagged with the requester id.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal range 2..4.
- IDW, 2: width of the requester id; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; combinational from current state and req_valid.
- req_wr  in  NREQ  1 = write (store a+b), 0 = read.
- req_addr  in  NREQ×6  cache address.
- req_a, req_b  in  NREQ×7 each  operands; ignored for reads.
- ren, wen  out  1 each  registered adder read and write enables.
- raddr, waddr  out  6 each  registered adder addresses.
- a, b  out  7 each  registered adder operands.
- q  in  8  adder read data.
- rsp_valid  out  1  read response valid.
- rsp_id  out  IDW  requester id of the response.
- rsp_data  out  8  equals q, unregistered.
- busy  out  1  high while any granted operation has not completed.

## Operation
- Handshake: requester i is accepted in the cycle where req_valid[i] and req_ready[i] are both high. req_ready is one-hot or zero. At most one grant per cycle.
- Eligibility: a write is always eligible. A read is ineligible if its address matches a write granted in either of the previous two cycles (2-entry tracker of valid+addr). A read is also ineligible while the cold counter is nonzero.
- Arbitration: round-robin among eligible requesters, starting at pointer rr.
  - After a grant to requester i, rr becomes (i+1) mod NREQ.
  - rr is unchanged when nothing is granted.
  - An ineligible request is skipped. It is not starved: its hazard clears within 2 cycles.
- Issue register: in the cycle after a grant, it drives wen or ren with its address and operands. In all other cycles ren=wen=0; addresses and operands hold their last values.
- Response: rsp_valid/rsp_id pulse two cycles after a read grant. rsp_data = q.
- busy: high if the tracker holds a write, the issue register is active, or the response pipeline is active.
- Reset (asserted at any time): clears rr=0, ren=wen=0, the tracker, rsp_valid=0, rsp_id=0, addresses and operands to 0, and busy=0. It loads the cold counter with 2.
  - The adder has no reset, so up to 2 writes may already be in its pipeline and still commit.
  - Reads are therefore blocked for 2 cycles after reset deassertion. Writes are accepted immediately.
  - Responses for reads in flight when reset asserts are dropped.

## Timing
- Read: grant at cycle g, ren in g+1, rsp_valid in g+2. Latency 2.
- Write: grant at g, wen in g+1, RAM updated at the end of g+3. A read granted at g+3 or later returns the new value. Reads granted at g+1 or g+2 to the same address stall.
- Throughput: 1 op/cycle with no hazards. Writes and reads to different addresses interleave without bubbles.
- Address 63 and address 0 are ordinary entries. Address comparison is exact, 6 bits, with no wrap aliasing.
- Operands pass unmodified. Sum width (8 bits, carry in bit 7) is the adder's concern.

## Structure
- Package adder_cache_pkg holds: ADDR_W=6, OP_W=7, DATA_W=8, WR_HAZARD_DEPTH=2, COLD_CYCLES=2, and the op type (OP_RD=0, OP_WR=1).
- One sub-module, rr_arbiter: a parameterised NREQ round-robin with an eligibility mask and one-hot grant.
- The hazard tracker, issue register and response pipeline stay in the top module.

## Test plan
- Single requester: write addr 5, a=3, b=4 at g; read addr 5 at g+3 → rsp_valid at g+5, rsp_id=0, rsp_data=8'd7.
- RAW hazard: req0 writes addr 9 (a=127, b=1) at g; req1 reads addr 9 continuously from g+1 → req_ready[1] low at g+1 and g+2, granted g+3, rsp_data=8'd128.
- Fairness: both requesters read distinct addresses every cycle → grants alternate 0,1,0,1. After reset the first grant is requester 0.
- Bypass of a blocked requester: req0 reads a hazarded address while req1 writes addr 20 → req1 is granted that cycle, with no idle cycle.
- Reset mid-operation: assert rst one cycle after a read grant → no rsp_valid. After deassertion, reads are blocked for 2 cycles and a write is accepted in the first cycle.
- Back-to-back writes to addr 63 then addr 0, each followed by a read at +3 → correct sums returned, and busy drops 2 cycles after the last read grant.

Source files
------------

// File: rtl/adder_cache_pkg.sv
// Shared widths, timing constants and types for the adder cache scheduler.
package adder_cache_pkg;
   localparam int ADDR_W          = 6;
   localparam int OP_W            = 7;
   localparam int DATA_W          = 8;
   localparam int WR_HAZARD_DEPTH = 2;
   localparam int COLD_CYCLES     = 2;

   typedef enum logic { OP_RD = 1'b0, OP_WR = 1'b1 } op_e;

   // One slot of the in-flight write tracker.
   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] addr;
   } wr_trk_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, pointer moves past the winner.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] elig_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_id_o,
   output logic            gnt_vld_o
);
   logic [IDW-1:0] rr_q, rr_d;

   // Scan from the pointer and take the first eligible requester.
   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_id_o  = '0;
      gnt_vld_o = 1'b0;
      idx       = 0;
      for (int j = 0; j < NREQ; j++) begin
         idx = (int'(rr_q) + j) % NREQ;
         if (!gnt_vld_o && elig_i[idx]) begin
            gnt_vld_o   = 1'b1;
            gnt_o[idx]  = 1'b1;
            gnt_id_o    = IDW'(idx);
         end
      end
   end

   // Pointer lands one past the winner; idle cycles leave it alone.
   always_comb begin
      rr_d = rr_q;
      if (gnt_vld_o) begin
         if (int'(gnt_id_o) == NREQ - 1) rr_d = '0;
         else                            rr_d = gnt_id_o + IDW'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end
endmodule

// File: rtl/adder_cache_scheduler.sv
// Shares the pipelined adder cache among NREQ requesters: arbitration, RAW blocking,
// registered issue to the adder and an id-tagged read response.
module adder_cache_scheduler
   import adder_cache_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ-1:0]             req_wr,
   input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NREQ-1:0][OP_W-1:0]   req_a,
   input  logic [NREQ-1:0][OP_W-1:0]   req_b,
   output logic                        ren,
   output logic                        wen,
   output logic [ADDR_W-1:0]           raddr,
   output logic [ADDR_W-1:0]           waddr,
   output logic [OP_W-1:0]             a,
   output logic [OP_W-1:0]             b,
   input  logic [DATA_W-1:0]           q,
   output logic                        rsp_valid,
   output logic [IDW-1:0]              rsp_id,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        busy
);
   localparam int COLD_W = $clog2(COLD_CYCLES + 1);

   wr_trk_t           trk_q [WR_HAZARD_DEPTH];
   wr_trk_t           trk_d [WR_HAZARD_DEPTH];
   logic [COLD_W-1:0] cold_q, cold_d;
   logic              ren_q, ren_d, wen_q, wen_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [IDW-1:0]    iss_id_q, iss_id_d;
   logic              rsp_valid_q;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;

   logic [NREQ-1:0]   rd_hit, elig, gnt;
   logic [IDW-1:0]    gnt_id;
   logic              gnt_vld;
   op_e               gnt_op;
   logic [ADDR_W-1:0] gnt_addr;
   logic [OP_W-1:0]   gnt_a, gnt_b;
   logic              trk_busy;

   // A read is held back during the cold window or while its address is still in the adder pipe.
   always_comb begin
      rd_hit = '0;
      elig   = '0;
      for (int i = 0; i < NREQ; i++) begin
         for (int k = 0; k < WR_HAZARD_DEPTH; k++)
            if (trk_q[k].vld && trk_q[k].addr == req_addr[i]) rd_hit[i] = 1'b1;
         elig[i] = req_valid[i] && (req_wr[i] || (cold_q == '0 && !rd_hit[i]));
      end
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .elig_i    (elig),
      .gnt_o     (gnt),
      .gnt_id_o  (gnt_id),
      .gnt_vld_o (gnt_vld)
   );

   assign req_ready = gnt;

   // Select the winning request's fields; grant is one-hot so an OR-style pick is safe.
   always_comb begin
      gnt_op   = OP_RD;
      gnt_addr = '0;
      gnt_a    = '0;
      gnt_b    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_op   = req_wr[i] ? OP_WR : OP_RD;
            gnt_addr = req_addr[i];
            gnt_a    = req_a[i];
            gnt_b    = req_b[i];
         end
      end
   end

   // Next state for the write tracker, cold countdown, issue register and response stage.
   always_comb begin
      trk_d[0].vld  = gnt_vld && (gnt_op == OP_WR);
      trk_d[0].addr = gnt_addr;
      for (int k = 1; k < WR_HAZARD_DEPTH; k++) trk_d[k] = trk_q[k-1];
      cold_d   = (cold_q != '0) ? cold_q - COLD_W'(1) : cold_q;
      ren_d    = gnt_vld && (gnt_op == OP_RD);
      wen_d    = gnt_vld && (gnt_op == OP_WR);
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      a_d      = a_q;
      b_d      = b_q;
      iss_id_d = iss_id_q;
      if (ren_d) begin
         raddr_d  = gnt_addr;
         iss_id_d = gnt_id;
      end
      if (wen_d) begin
         waddr_d = gnt_addr;
         a_d     = gnt_a;
         b_d     = gnt_b;
      end
      rsp_id_d = ren_q ? iss_id_q : rsp_id_q;
   end

   // State registers; reset drops in-flight responses and restarts the cold window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < WR_HAZARD_DEPTH; k++) trk_q[k] <= '0;
         cold_q      <= COLD_W'(COLD_CYCLES);
         ren_q       <= 1'b0;
         wen_q       <= 1'b0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         iss_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         for (int k = 0; k < WR_HAZARD_DEPTH; k++) trk_q[k] <= trk_d[k];
         cold_q      <= cold_d;
         ren_q       <= ren_d;
         wen_q       <= wen_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         iss_id_q    <= iss_id_d;
         rsp_valid_q <= ren_q;
         rsp_id_q    <= rsp_id_d;
      end
   end

   // Any tracked write means the adder still has work outstanding.
   always_comb begin
      trk_busy = 1'b0;
      for (int k = 0; k < WR_HAZARD_DEPTH; k++) trk_busy = trk_busy | trk_q[k].vld;
   end

   assign ren       = ren_q;
   assign wen       = wen_q;
   assign raddr     = raddr_q;
   assign waddr     = waddr_q;
   assign a         = a_q;
   assign b         = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = q;
   assign busy      = trk_busy | ren_q | wen_q | rsp_valid_q;
endmodule

// File: tb/tb_adder_cache_scheduler.sv
// Bench for adder_cache_scheduler: behavioural adder cache plus a cycle-indexed reference model.
module tb_adder_cache_scheduler;
   localparam int NREQ = 2;
   localparam int IDW  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid, req_ready, req_wr;
   logic [NREQ-1:0][5:0]  req_addr;
   logic [NREQ-1:0][6:0]  req_a, req_b;
   logic                  ren, wen, rsp_valid, busy;
   logic [5:0]            raddr, waddr;
   logic [6:0]            a, b;
   logic [7:0]            q, rsp_data;
   logic [IDW-1:0]        rsp_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_cache_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_a(req_a), .req_b(req_b), .ren(ren), .wen(wen),
      .raddr(raddr), .waddr(waddr), .a(a), .b(b), .q(q), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   // Adder cache: two pipeline stages then RAM write; registered read port; no reset.
   logic [7:0] ram [64] = '{default: 8'h00};
   logic       p1_v = 1'b0, p2_v = 1'b0;
   logic [5:0] p1_a = '0, p2_a = '0;
   logic [7:0] p1_s = '0, p2_s = '0, q_r = '0;
   always @(posedge clk) begin
      p1_v <= wen;  p1_a <= waddr; p1_s <= {1'b0, a} + {1'b0, b};
      p2_v <= p1_v; p2_a <= p1_a;  p2_s <= p1_s;
      if (p2_v) ram[p2_a] <= p2_s;
      if (ren)  q_r <= ram[raddr];
   end
   assign q = q_r;

   // Reference model, indexed by cycle number.
   int         cyc = 0, m_rr = 0, m_rel = 0, m_last_any = -100;
   int         m_last_wr [64];
   logic [7:0] m_mem [64] = '{default: 8'h00};
   bit         rd0_v, rd1_v, pg_v, pg_wr;
   int         rd0_id, rd1_id, exp_gnt;
   logic [7:0] rd0_d, rd1_d;
   logic [5:0] pg_addr;
   logic [6:0] pg_a, pg_b;
   logic [NREQ-1:0] exp_ready;
   bit         exp_busy;

   task automatic model_reset();
      m_rr = 0; rd0_v = 0; rd1_v = 0; pg_v = 0; m_last_any = -100;
      for (int i = 0; i < 64; i++) m_last_wr[i] = -100;
   endtask

   task automatic model_eval();
      exp_gnt = -1;
      for (int j = 0; j < NREQ; j++) begin
         int i;
         i = (m_rr + j) % NREQ;
         if (exp_gnt < 0 && req_valid[i] &&
             (req_wr[i] || (cyc >= m_rel + 2 && cyc - m_last_wr[req_addr[i]] >= 3)))
            exp_gnt = i;
      end
      exp_ready = '0;
      if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
      exp_busy = (cyc - m_last_any >= 1) && (cyc - m_last_any <= 2);
   endtask

   task automatic model_commit();
      model_eval();
      if (rst) begin
         model_reset();
         m_rel = cyc + 1;
      end else begin
         rd1_v = rd0_v; rd1_id = rd0_id; rd1_d = rd0_d;
         rd0_v = 0; pg_v = 0;
         if (exp_gnt >= 0) begin
            pg_v = 1; pg_wr = req_wr[exp_gnt]; pg_addr = req_addr[exp_gnt];
            pg_a = req_a[exp_gnt]; pg_b = req_b[exp_gnt];
            m_last_any = cyc;
            m_rr = (exp_gnt + 1) % NREQ;
            if (pg_wr) begin
               m_mem[pg_addr] = 8'(int'(pg_a) + int'(pg_b));
               m_last_wr[pg_addr] = cyc;
            end else begin
               rd0_v = 1; rd0_id = exp_gnt; rd0_d = m_mem[pg_addr];
            end
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic clr_req();
      req_valid = '0; req_wr = '0; req_addr = '0; req_a = '0; req_b = '0;
   endtask

   task automatic set_req(input int i, input bit wr, input logic [5:0] ad, input logic [6:0] av, input logic [6:0] bv);
      req_valid[i] = 1'b1; req_wr[i] = wr; req_addr[i] = ad; req_a[i] = av; req_b[i] = bv;
   endtask

   task automatic idle(input int n);
      clr_req();
      repeat (n) step();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clr_req();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clr_req();
      @(negedge clk);
      step();
      step();
      #1;
      checks++; if ({ren, wen, rsp_valid, busy} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {ren, wen, rsp_valid, busy}); end
      checks++; if ({raddr, waddr, a, b} !== 26'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {raddr, waddr, a, b}); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      rst = 1'b0;
      set_req(0, 0, 6'd3, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cold_rd0: got %b want 00", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cold_rd1: got %b want 00", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cold_rd2: got %b want 01", req_ready); end
      step();
      idle(3);
   endtask

   task automatic test_single();
      set_req(0, 1, 6'd5, 7'd3, 7'd4);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_wr_ready: got %b want 01", req_ready); end
      step();
      clr_req();
      #1;
      checks++; if ({wen, ren, waddr, a, b} !== {1'b1, 1'b0, 6'd5, 7'd3, 7'd4}) begin errors++; $display("FAIL single_issue_wr: got %h", {wen, ren, waddr, a, b}); end
      step();
      step();
      set_req(0, 0, 6'd5, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_rd_ready: got %b want 01", req_ready); end
      step();
      clr_req();
      #1;
      checks++; if ({ren, raddr, rsp_valid} !== {1'b1, 6'd5, 1'b0}) begin errors++; $display("FAIL single_issue_rd: got %h", {ren, raddr, rsp_valid}); end
      step();
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'd7}) begin errors++; $display("FAIL single_rsp: got v=%b id=%0d d=%0d want v=1 id=0 d=7", rsp_valid, rsp_id, rsp_data); end
      step();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0", rsp_valid); end
      idle(2);
   endtask

   task automatic test_raw();
      set_req(0, 1, 6'd9, 7'd127, 7'd1);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL raw_wr: got %b want 01", req_ready); end
      step();
      clr_req();
      set_req(1, 0, 6'd9, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL raw_block1: got %b want 00", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL raw_block2: got %b want 00", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL raw_grant: got %b want 10", req_ready); end
      step();
      clr_req();
      step();
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'd128}) begin errors++; $display("FAIL raw_rsp: got v=%b id=%0d d=%0d want v=1 id=1 d=128", rsp_valid, rsp_id, rsp_data); end
      idle(2);
   endtask

   task automatic test_bypass();
      set_req(1, 1, 6'd30, 7'd1, 7'd2);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bypass_setup: got %b want 10", req_ready); end
      step();
      clr_req();
      set_req(0, 0, 6'd30, 7'd0, 7'd0);
      set_req(1, 1, 6'd20, 7'd5, 7'd6);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bypass_grant: got %b want 10", req_ready); end
      step();
      clr_req();
      #1;
      checks++; if ({wen, waddr, a, b} !== {1'b1, 6'd20, 7'd5, 7'd6}) begin errors++; $display("FAIL bypass_issue: got %h", {wen, waddr, a, b}); end
      idle(3);
   endtask

   task automatic test_back_to_back();
      set_req(0, 1, 6'd63, 7'd100, 7'd50);
      step();
      clr_req();
      set_req(0, 1, 6'd0, 7'd127, 7'd127);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_wr2: got %b want 01", req_ready); end
      step();
      idle(1);
      set_req(0, 0, 6'd63, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_rd63: got %b want 01", req_ready); end
      step();
      clr_req();
      set_req(1, 0, 6'd0, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_rd0: got %b want 10", req_ready); end
      step();
      clr_req();
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_data, busy} !== {1'b1, 2'd0, 8'd150, 1'b1}) begin errors++; $display("FAIL b2b_rsp63: got v=%b id=%0d d=%0d busy=%b", rsp_valid, rsp_id, rsp_data, busy); end
      step();
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'd254}) begin errors++; $display("FAIL b2b_rsp0: got v=%b id=%0d d=%0d", rsp_valid, rsp_id, rsp_data); end
      step();
      #1;
      checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got busy=%b v=%b want 0 0", busy, rsp_valid); end
      idle(1);
   endtask

   task automatic test_fairness();
      apply_reset();
      idle(2);
      for (int k = 0; k < 6; k++) begin
         set_req(0, 0, 6'd10, 7'd0, 7'd0);
         set_req(1, 0, 6'd11, 7'd0, 7'd0);
         #1;
         checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL fair_grant%0d: got %b", k, req_ready); end
         if (k >= 2) begin
            checks++; if (rsp_valid !== 1'b1 || int'(rsp_id) != k % 2) begin errors++; $display("FAIL fair_rsp%0d: got v=%b id=%0d want id %0d", k, rsp_valid, rsp_id, k % 2); end
         end
         step();
      end
      idle(3);
   endtask

   task automatic test_reset_mid();
      set_req(0, 0, 6'd40, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_rd: got %b want 01", req_ready); end
      step();
      clr_req();
      rst = 1'b1;
      #1;
      checks++; if ({ren, rsp_valid, busy} !== 3'b000) begin errors++; $display("FAIL rmid_clear: got %b want 000", {ren, rsp_valid, busy}); end
      step();
      rst = 1'b0;
      set_req(0, 0, 6'd41, 7'd0, 7'd0);
      set_req(1, 1, 6'd42, 7'd9, 7'd9);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rmid_first_wr: got %b want 10", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got %b want 0", rsp_valid); end
      step();
      clr_req();
      set_req(0, 0, 6'd41, 7'd0, 7'd0);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_cold: got %b want 00", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_rd_ok: got %b want 01", req_ready); end
      step();
      idle(3);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         clr_req();
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(3) != 0) begin
               int r;
               r = int'($urandom_range(3));
               set_req(i, $urandom_range(1) == 1, (r == 3) ? 6'd63 : 6'(r), 7'($urandom), 7'($urandom));
            end
         end
         #1;
         model_eval();
         checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_ready); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, exp_busy); end
         checks++; if (rsp_valid !== rd1_v) begin errors++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, rd1_v); end
         if (rd1_v) begin
            checks++; if (rsp_id !== IDW'(rd1_id) || rsp_data !== rd1_d) begin errors++; $display("FAIL rnd_rsp@%0d: got id=%0d d=%0d want id=%0d d=%0d", cyc, rsp_id, rsp_data, rd1_id, rd1_d); end
         end
         checks++; if ({ren, wen} !== {pg_v && !pg_wr, pg_v && pg_wr}) begin errors++; $display("FAIL rnd_issue@%0d: got ren=%b wen=%b", cyc, ren, wen); end
         if (pg_v && pg_wr) begin
            checks++; if ({waddr, a, b} !== {pg_addr, pg_a, pg_b}) begin errors++; $display("FAIL rnd_wr_fields@%0d: got %h want %h", cyc, {waddr, a, b}, {pg_addr, pg_a, pg_b}); end
         end
         if (pg_v && !pg_wr) begin
            checks++; if (raddr !== pg_addr) begin errors++; $display("FAIL rnd_raddr@%0d: got %0d want %0d", cyc, raddr, pg_addr); end
         end
         step();
      end
      idle(4);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_raw();
      test_bypass();
      test_back_to_back();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
